mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency 64-bit memory between the 5-stage pipeline's instruction fetch (IF) and data access (MEM) stages.
- Grants one requester at a time and holds the memory request stable until acknowledged.
- Returns data with a one-cycle ready strobe; the pipeline stalls while ready is low.
- Also provides starvation protection for fetch, cancellation of flushed fetches, and a transaction timeout.

Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch waits; the next grant goes to fetch.
- TIMEOUT, 255: cycles a granted transaction may wait for mem_ack before it is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  64  fetch byte address (PC).
- if_flush  in  1  branch flush; cancels the pending or arriving fetch.
- if_rdata  out  32  instruction word, valid when if_ready.
- if_ready  out  1  fetch complete strobe.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_rdata  out  64  load data, valid when d_ready.
- d_ready  out  1  data complete strobe.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  64  memory address, registered.
- mem_wdata  out  64  memory write data, registered.
- mem_rdata  in  64  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: state IDLE; all outputs 0; burst and timeout counters 0. Reset asserted mid-transaction drops mem_req immediately (asynchronous); an in-flight ack after reset is ignored.
- States: IDLE, GRANT_I, GRANT_D, DISCARD.
- IDLE arbitration, evaluated at each clock edge:
  - d_req && (!if_req || burst_cnt < MAX_DATA_BURST) -> GRANT_D.
  - else if_req && !if_flush -> GRANT_I.
  - else stay in IDLE.
- On a grant, mem_addr/mem_we/mem_wdata are latched from the winner and mem_req is set. These hold unchanged until ack or timeout. Fetch grants force mem_we = 0 and mem_wdata = 0.
- burst_cnt:
  - +1 on each data grant while if_req = 1, saturating at MAX_DATA_BURST.
  - Cleared on a fetch grant, and on any edge with if_req = 0.
- GRANT_I:
  - mem_ack && !if_flush -> if_ready = 1 in the same cycle (combinational from mem_ack). if_rdata = mem_rdata[63:32] if mem_addr[2] else mem_rdata[31:0]. Next state IDLE, mem_req cleared.
  - if_flush without mem_ack -> DISCARD; mem_req stays high.
  - if_flush together with mem_ack -> no if_ready; next state IDLE.
- DISCARD: wait for mem_ack, suppress if_ready, then IDLE. The stale fetch is never delivered.
- GRANT_D: mem_ack -> d_ready = 1 and d_rdata = mem_rdata in the same cycle; next state IDLE. For stores, d_rdata = 0.
- Latency: request sampled in IDLE at edge t; mem_req high in cycle t+1; minimum ready in cycle t+1 (ack in the first request cycle). One IDLE cycle separates back-to-back transactions.
- Requester protocol: the requester deasserts or changes its request in the cycle after ready. The arbiter must not regrant from the ready cycle, because IDLE samples only at the following edge.
- Timeout:
  - tmo_cnt clears on grant and increments each cycle in GRANT_I/GRANT_D/DISCARD without mem_ack.
  - When tmo_cnt == TIMEOUT with no ack: drop mem_req, set err (sticky until reset), return IDLE.
  - The owning requester gets ready = 1 with zero data so the pipeline cannot hang. DISCARD timeout asserts no ready.
- if_ready and d_ready are never high in the same cycle. The ready outputs are the only combinational outputs; all mem_* outputs are registered.

Decomposition:
- Shared package holds the state encoding (2-bit localparams IDLE = 0, GRANT_I = 1, GRANT_D = 2, DISCARD = 3) and the default MAX_DATA_BURST/TIMEOUT constants, for reuse by the pipeline stall logic.
- One sub-module: arb_timeout_counter (clear, enable, expired output).
- Arbitration FSM and burst counter stay in the top module.

Test Plan:
- Fetch only: if_req, if_addr = 0x4; memory acks 2 cycles after mem_req with mem_rdata = 0x11112222_33334444 -> mem_addr = 0x4, if_ready one cycle, if_rdata = 0x11112222; exactly one mem_req transaction.
- Simultaneous if_req and d_req (load, d_addr = 0x100, ack next cycle) -> GRANT_D first, d_ready with data; then fetch is granted after one IDLE cycle.
- Continuous d_req with if_req held, MAX_DATA_BURST = 4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- if_flush one cycle after fetch grant, ack 3 cycles later -> no if_ready; next fetch (new if_addr = 0x40) is granted after the ack and returns its own data.
- Store d_we = 1, d_wdata = 0xDEADBEEF, no ack for TIMEOUT cycles -> mem_req drops, d_ready pulses with d_rdata = 0, err = 1 and stays 1 until reset.
- Reset asserted while GRANT_D pending -> mem_req = 0 asynchronously, state IDLE; a later mem_ack produces no ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: state encoding and
// default limits, also used by the pipeline stall logic.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DISCARD = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_MAX_DATA_BURST = 4;
    localparam int unsigned DEF_TIMEOUT        = 255;
    localparam int unsigned DEF_CNT_W          = 8;

    // Instructions are 32-bit; address bit 2 picks the half of the 64-bit beat.
    function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic upper);
        return upper ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Transaction watchdog: counts cycles while enabled, flags when TIMEOUT is reached.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

    // Holds at TIMEOUT so the flag cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency 64-bit memory port between instruction fetch
// and data access, with fetch starvation guard, flush discard and timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_BURST = DEF_MAX_DATA_BURST,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int unsigned BURST_W = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    // Handshake: a requester holds req and its operands stable until its ready
    // pulses for one cycle; in the next cycle it must drop or change the request.
    arb_state_t          state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [63:0]         mem_addr_q, mem_addr_d;
    logic [63:0]         mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic                busy;
    logic                tmo_expired;
    logic                data_wins;

    assign busy      = (state_q != IDLE);
    assign data_wins = d_req && (!if_req || (burst_q < BURST_MAX));

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (!busy),
        .en_i      (busy && !mem_ack),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        if_ready    = 1'b0;
        if_rdata    = '0;
        d_ready     = 1'b0;
        d_rdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (burst_q < BURST_MAX) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else if (if_req && !if_flush) begin
                    state_d     = GRANT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    burst_d     = '0;
                end
            end
            GRANT_I: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    if (!if_flush) begin
                        if_ready = 1'b1;
                        if_rdata = fetch_word(mem_rdata, mem_addr_q[2]);
                    end
                end else if (tmo_expired) begin
                    state_d  = IDLE;
                    if_ready = !if_flush;
                end else if (if_flush) begin
                    state_d = DISCARD;
                end
            end
            GRANT_D: begin
                if (mem_ack || tmo_expired) begin
                    state_d = IDLE;
                    d_ready = 1'b1;
                    if (mem_ack && !mem_we_q) begin
                        d_rdata = mem_rdata;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack || tmo_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (busy && (mem_ack || tmo_expired)) begin
            mem_req_d = 1'b0;
        end
        if (busy && tmo_expired && !mem_ack) begin
            err_d = 1'b1;
        end
        if (!if_req) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_ready;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_ready;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack, err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_DATA_BURST (4),
        .TIMEOUT        (TMO),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    logic        fix_en = 1'b0;
    logic [63:0] fix_val = '0;
    logic        stray_ack = 1'b0;
    int          n_txn = 0;
    int          last_len = 0;
    logic [31:0] last_if_rdata = '0;
    logic [63:0] last_d_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (fix_en) return fix_val;
        return {a[31:0] ^ 32'hCAFE_F00D, ~a[31:0]};
    endfunction

    function automatic void push_exp(input logic is_d, input logic [63:0] addr,
                                     input logic we, input logic [63:0] wdata);
        txn_t t;
        t.is_d  = is_d;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        exp_q.push_back(t);
    endfunction

    // Memory responder: acks ack_delay cycles after the first request cycle.
    initial begin : responder
        bit busy;
        int waited;
        busy      = 0;
        waited    = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (reset || !mem_req) begin
                busy = 0;
                if (stray_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 64'hFEED_FACE_0BAD_F00D;
                end
            end else begin
                if (!busy) begin
                    busy   = 1;
                    waited = 0;
                end
                if (waited == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                end
                waited++;
            end
        end
    end

    // Reference model: each memory transaction is the next expected grant; it ends
    // on ack or after TMO+1 request cycles, and its owner gets exactly one ready.
    initial begin : model
        txn_t        cur;
        bit          in_txn, flushed, gap, err_exp, done, tmo;
        int          age;
        logic        exp_ir, exp_dr;
        logic [31:0] exp_ird;
        logic [63:0] exp_drd, w;
        cur = '0; in_txn = 0; flushed = 0; gap = 0; err_exp = 0; age = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_txn = 0; gap = 0; flushed = 0; err_exp = 0;
                chk("rst_mem_req", mem_req, 0);
                chk("rst_ready", {if_ready, d_ready}, 0);
                chk("rst_err", err, 0);
            end else begin
                exp_ir = 0; exp_dr = 0; exp_ird = '0; exp_drd = '0; done = 0; tmo = 0;
                if (gap) begin
                    chk("idle_gap", mem_req, 0);
                    gap = 0;
                end else if (!in_txn && mem_req) begin
                    chk("grant_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    in_txn = 1; age = 0; flushed = 0; n_txn++;
                end
                if (in_txn) begin
                    chk("mem_req", mem_req, 1);
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", mem_we, cur.we);
                    chk("mem_wdata", mem_wdata, cur.wdata);
                    if (mem_ack) done = 1;
                    else if (age == TMO) begin done = 1; tmo = 1; end
                    if (done) begin
                        w = mem_fn(cur.addr);
                        if (cur.is_d) begin
                            exp_dr  = 1;
                            exp_drd = (mem_ack && !cur.we) ? w : 64'd0;
                        end else if (!flushed && !if_flush) begin
                            exp_ir  = 1;
                            exp_ird = !mem_ack ? 32'd0 : (cur.addr[2] ? w[63:32] : w[31:0]);
                        end
                    end else if (!cur.is_d && if_flush) begin
                        flushed = 1;
                    end
                end
                chk("if_ready", if_ready, exp_ir);
                chk("d_ready", d_ready, exp_dr);
                if (exp_ir) begin
                    chk("if_rdata", if_rdata, exp_ird);
                    last_if_rdata = if_rdata;
                end
                if (exp_dr) begin
                    chk("d_rdata", d_rdata, exp_drd);
                    last_d_rdata = d_rdata;
                end
                chk("err", err, err_exp);
                if (done) begin
                    in_txn = 0; gap = 1; last_len = age + 1;
                    if (tmo) err_exp = 1;
                end
                age++;
            end
        end
    end

    task automatic wait_if_ready();
        int t = 0;
        do begin @(negedge clk); t++; end while (!if_ready && t < 600);
        chk("if_ready_wait", if_ready, 1);
    endtask

    task automatic wait_d_ready();
        int t = 0;
        do begin @(negedge clk); t++; end while (!d_ready && t < 600);
        chk("d_ready_wait", d_ready, 1);
    endtask

    task automatic fetch_agent(input int n, input logic [63:0] base);
        if_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            if_addr = base + 64'(4 * k);
            wait_if_ready();
            @(posedge clk); #2;
        end
        if_req = 1'b0;
    endtask

    task automatic data_agent(input int n, input logic [63:0] base, input logic we,
                              input logic [63:0] wdata);
        d_req = 1'b1; d_we = we; d_wdata = wdata;
        for (int k = 0; k < n; k++) begin
            d_addr = base + 64'(8 * k);
            wait_d_ready();
            @(posedge clk); #2;
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", {mem_req, mem_we, err, if_ready, d_ready}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);

        // Fetch only, ack two cycles after the request appears.
        fix_en = 1'b1; fix_val = 64'h1111_2222_3333_4444; ack_delay = 2;
        push_exp(0, 64'h4, 0, 0);
        n0 = n_txn;
        @(posedge clk); #2 if_addr = 64'h4; if_req = 1'b1;
        @(negedge clk); chk("t1_req_before_edge", mem_req, 0);
        @(negedge clk); chk("t1_req_after_edge", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 64'h4);
        wait_if_ready();
        chk("t1_if_rdata", if_rdata, 32'h1111_2222);
        @(posedge clk); #2 if_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_one_txn", n_txn - n0, 1);

        // Simultaneous requests: data wins, fetch follows after one idle cycle.
        fix_val = 64'h0123_4567_89AB_CDEF; ack_delay = 1;
        push_exp(1, 64'h100, 0, 0);
        push_exp(0, 64'h200, 0, 0);
        @(posedge clk); #2;
        fork
            fetch_agent(1, 64'h200);
            data_agent(1, 64'h100, 0, 0);
        join
        chk("t2_d_rdata", last_d_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t2_if_rdata", last_if_rdata, 32'h89AB_CDEF);

        // Continuous data with fetch held: D,D,D,D,I,D,D,D,D,I at minimum latency.
        fix_en = 1'b0; ack_delay = 0;
        for (int k = 0; k < 4; k++) push_exp(1, 64'h1000 + 64'(8 * k), 0, 0);
        push_exp(0, 64'h2000, 0, 0);
        for (int k = 4; k < 8; k++) push_exp(1, 64'h1000 + 64'(8 * k), 0, 0);
        push_exp(0, 64'h2004, 0, 0);
        @(posedge clk); #2;
        fork
            fetch_agent(2, 64'h2000);
            data_agent(8, 64'h1000, 0, 0);
        join
        chk("t3_queue_drained", exp_q.size(), 0);

        // Flush after grant: stale fetch discarded, redirected fetch delivered.
        ack_delay = 4;
        push_exp(0, 64'h20, 0, 0);
        push_exp(0, 64'h40, 0, 0);
        n0 = n_txn;
        @(posedge clk); #2 if_addr = 64'h20; if_req = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2 if_flush = 1'b1; if_addr = 64'h40;
        @(posedge clk); #2 if_flush = 1'b0;
        wait_if_ready();
        chk("t4_if_rdata", if_rdata, 32'hFFFF_FFBF);
        @(posedge clk); #2 if_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_two_txn", n_txn - n0, 2);

        // Store with no ack: timeout aborts, ready with zero data, sticky err.
        ack_delay = 1000;
        push_exp(1, 64'h300, 1, 64'hDEAD_BEEF);
        data_agent(1, 64'h300, 1, 64'hDEAD_BEEF);
        chk("t5_len", last_len, TMO + 1);
        chk("t5_d_rdata", last_d_rdata, 0);
        @(negedge clk); chk("t5_err_set", err, 1);
        chk("t5_req_dropped", mem_req, 0);
        ack_delay = 1;
        push_exp(1, 64'h400, 1, 64'h55);
        push_exp(1, 64'h408, 0, 0);
        data_agent(1, 64'h400, 1, 64'h55);
        data_agent(1, 64'h408, 0, 0);
        @(negedge clk); chk("t5_err_sticky", err, 1);

        // Async reset mid data transaction; a later stray ack yields no ready.
        ack_delay = 1000;
        push_exp(1, 64'h500, 0, 0);
        @(posedge clk); #2 d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("t6_req_before", mem_req, 1);
        #1 reset = 1'b1;
        #1 chk("t6_req_async", mem_req, 0);
        d_req = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); chk("t6_err_cleared", err, 0);
        @(posedge clk); #2 stray_ack = 1'b1;
        @(negedge clk); chk("t6_no_ready", {if_ready, d_ready}, 0);
        @(posedge clk); #2 stray_ack = 1'b0;
        ack_delay = 0;
        push_exp(0, 64'h8, 0, 0);
        fetch_agent(1, 64'h8);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
